// File: rtl/id_ex_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants: opcode/control widths, control bit
//               positions and the NOP control encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int OPCODE_W = 4;
  localparam int CTRL_W   = 9;
  localparam int COND_W   = 4;
  localparam int RD_W     = 4;
  localparam int SHIFT_W  = 12;

  localparam int CTRL_AM     = 8;
  localparam int CTRL_S      = 7;
  localparam int CTRL_LOAD   = 6;
  localparam int CTRL_RF     = 5;
  localparam int CTRL_SIZE   = 4;
  localparam int CTRL_RW     = 3;
  localparam int CTRL_ENABLE = 2;
  localparam int CTRL_BL     = 1;
  localparam int CTRL_B      = 0;

  typedef logic [CTRL_W-1:0]   ctrl_t;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t NOP_OPCODE = 4'b1110;
  // All-zero control disables RF write, memory, flag update and branch in EX.
  localparam ctrl_t   NOP_CTRL   = '0;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/id_ex_register_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_if
// Description : ID-to-EX pipeline bus: decoded ID fields, pipeline controls
//               and registered EX-stage outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import pipeline_pkg::*;

  opcode_t             id_opcode;
  ctrl_t               id_ctrl;
  logic [COND_W-1:0]   id_cond;
  logic [RD_W-1:0]     id_rd;
  logic [DATA_W-1:0]   id_op_a;
  logic [DATA_W-1:0]   id_op_b;
  logic [DATA_W-1:0]   id_op_c;
  logic [SHIFT_W-1:0]  id_shift_imm;
  logic [DATA_W-1:0]   id_pc;
  logic                id_valid;
  logic                hold;
  logic                bubble;
  logic                flush;

  opcode_t             ex_opcode;
  ctrl_t               ex_ctrl;
  logic [COND_W-1:0]   ex_cond;
  logic [RD_W-1:0]     ex_rd;
  logic [DATA_W-1:0]   ex_op_a;
  logic [DATA_W-1:0]   ex_op_b;
  logic [DATA_W-1:0]   ex_op_c;
  logic [SHIFT_W-1:0]  ex_shift_imm;
  logic [DATA_W-1:0]   ex_pc;
  logic                ex_valid;
  logic [CNT_W-1:0]    bubble_count;

  modport master (
    output id_opcode, id_ctrl, id_cond, id_rd, id_op_a, id_op_b, id_op_c,
           id_shift_imm, id_pc, id_valid, hold, bubble, flush,
    input  ex_opcode, ex_ctrl, ex_cond, ex_rd, ex_op_a, ex_op_b, ex_op_c,
           ex_shift_imm, ex_pc, ex_valid, bubble_count
  );

  modport slave (
    input  id_opcode, id_ctrl, id_cond, id_rd, id_op_a, id_op_b, id_op_c,
           id_shift_imm, id_pc, id_valid, hold, bubble, flush,
    output ex_opcode, ex_ctrl, ex_cond, ex_rd, ex_op_a, ex_op_b, ex_op_c,
           ex_shift_imm, ex_pc, ex_valid, bubble_count
  );

endinterface : id_ex_if
`default_nettype wire

// File: rtl/id_ex_register_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Enabled pipeline register with async active-low reset and a
//               synchronous clear to a constant.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             en,
  input  wire logic             clr,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= clr ? CLEAR_VAL : d;
    end
  end

  assign q = r_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_register
// Description : ID/EX pipeline register with hold, flush and bubble handling
//               and a saturating count of inserted NOP slots.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input wire logic clk,
  input wire logic reset_n,
  id_ex_if.slave   bus
);

  localparam int C_CTL_W = OPCODE_W + CTRL_W + 1;
  localparam int C_DP_W  = COND_W + RD_W + (4 * DATA_W) + SHIFT_W;
  localparam logic [C_CTL_W-1:0] C_NOP_GRP = {NOP_OPCODE, NOP_CTRL, 1'b0};

  logic               w_load_en;
  logic               w_nop_event;
  logic               w_nop_sel;
  logic [C_CTL_W-1:0] w_ctl_d;
  logic [C_CTL_W-1:0] w_ctl_q;
  logic [C_DP_W-1:0]  w_dp_d;
  logic [C_DP_W-1:0]  w_dp_q;
  logic [CNT_W-1:0]   r_bubble_count;

  assign w_load_en   = ~bus.hold;
  assign w_nop_event = bus.flush | bus.bubble;
  // An empty ID slot also loads NOP control but is not a counted bubble.
  assign w_nop_sel   = w_nop_event | ~bus.id_valid;

  assign w_ctl_d = {bus.id_opcode, bus.id_ctrl, bus.id_valid};
  assign w_dp_d  = {bus.id_cond, bus.id_rd, bus.id_op_a, bus.id_op_b,
                    bus.id_op_c, bus.id_shift_imm, bus.id_pc};

  pipe_reg #(
    .WIDTH     (C_CTL_W),
    .RESET_VAL (C_NOP_GRP),
    .CLEAR_VAL (C_NOP_GRP)
  ) u_ctl_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_load_en),
    .clr     (w_nop_sel),
    .d       (w_ctl_d),
    .q       (w_ctl_q)
  );

  // Datapath always follows ID when not held; only control is squashed.
  pipe_reg #(
    .WIDTH     (C_DP_W),
    .RESET_VAL ('0),
    .CLEAR_VAL ('0)
  ) u_dp_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_load_en),
    .clr     (1'b0),
    .d       (w_dp_d),
    .q       (w_dp_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_count <= '0;
    end else if (w_load_en && w_nop_event && (r_bubble_count != {CNT_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign {bus.ex_opcode, bus.ex_ctrl, bus.ex_valid} = w_ctl_q;
  assign {bus.ex_cond, bus.ex_rd, bus.ex_op_a, bus.ex_op_b,
          bus.ex_op_c, bus.ex_shift_imm, bus.ex_pc} = w_dp_q;
  assign bus.bubble_count = r_bubble_count;

endmodule : id_ex_register
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_register
// Description : Directed self-checking bench for id_ex_register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_register;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  id_ex_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_ex_if #(.DATA_W(32), .CNT_W(4))  sat_bus ();

  id_ex_register #(.DATA_W(32), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  id_ex_register #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sat_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [8:0] ctrl, input logic [31:0] a,
                       input logic [31:0] pc, input logic valid);
    bus.id_opcode    = op;
    bus.id_ctrl      = ctrl;
    bus.id_op_a      = a;
    bus.id_pc        = pc;
    bus.id_valid     = valid;
  endtask

  task automatic test_reset();
    drive(4'h3, 9'h155, 32'h0000_0033, 32'h0000_0040, 1'b1);
    step();
    tests++; if (bus.ex_opcode !== 4'h3) begin fails++; $display("FAIL pre_reset_load opcode got %h exp 3", bus.ex_opcode); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (bus.ex_opcode !== 4'hE) begin fails++; $display("FAIL reset opcode got %h exp e", bus.ex_opcode); end
    tests++; if (bus.ex_ctrl !== 9'h0 || bus.ex_valid !== 1'b0) begin fails++; $display("FAIL reset ctrl/valid got %h/%b exp 0/0", bus.ex_ctrl, bus.ex_valid); end
    tests++; if (bus.ex_op_a !== 32'h0 || bus.ex_pc !== 32'h0 || bus.bubble_count !== 16'd0) begin fails++; $display("FAIL reset data/count got %h/%h/%0d exp 0/0/0", bus.ex_op_a, bus.ex_pc, bus.bubble_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_normal();
    drive(4'b0100, 9'b010100000, 32'h0000_0005, 32'h0000_0100, 1'b1);
    bus.id_cond = 4'hE; bus.id_rd = 4'h7; bus.id_op_b = 32'hA5A5_0001;
    bus.id_op_c = 32'hDEAD_BEEF; bus.id_shift_imm = 12'h123;
    #1;
    tests++; if (bus.ex_opcode !== 4'hE) begin fails++; $display("FAIL no_comb_path opcode got %h exp e", bus.ex_opcode); end
    step();
    tests++; if (bus.ex_opcode !== 4'b0100 || bus.ex_ctrl !== 9'b010100000 || bus.ex_valid !== 1'b1) begin fails++; $display("FAIL normal ctl got %h/%h/%b exp 4/0a0/1", bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
    tests++; if (bus.ex_op_a !== 32'h5 || bus.ex_op_b !== 32'hA5A5_0001 || bus.ex_op_c !== 32'hDEAD_BEEF) begin fails++; $display("FAIL normal ops got %h/%h/%h", bus.ex_op_a, bus.ex_op_b, bus.ex_op_c); end
    tests++; if (bus.ex_cond !== 4'hE || bus.ex_rd !== 4'h7 || bus.ex_shift_imm !== 12'h123 || bus.ex_pc !== 32'h100) begin fails++; $display("FAIL normal fields got %h/%h/%h/%h", bus.ex_cond, bus.ex_rd, bus.ex_shift_imm, bus.ex_pc); end
    tests++; if (bus.bubble_count !== 16'd0) begin fails++; $display("FAIL normal count got %0d exp 0", bus.bubble_count); end
  endtask

  task automatic test_bubble();
    bus.bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'h1, 9'h1FF, 32'd10 + 32'(i), 32'h200, 1'b1);
      step();
      tests++; if (bus.ex_ctrl !== 9'h0 || bus.ex_valid !== 1'b0 || bus.ex_opcode !== 4'hE) begin fails++; $display("FAIL bubble%0d ctl got %h/%h/%b exp e/0/0", i, bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
      tests++; if (bus.ex_op_a !== 32'd10 + 32'(i)) begin fails++; $display("FAIL bubble%0d op_a got %0d exp %0d", i, bus.ex_op_a, 10 + i); end
    end
    bus.bubble = 1'b0;
    tests++; if (bus.bubble_count !== 16'd3) begin fails++; $display("FAIL bubble count got %0d exp 3", bus.bubble_count); end
  endtask

  task automatic test_hold();
    drive(4'h2, 9'h1FF, 32'h77, 32'h300, 1'b1);
    step();
    bus.hold = 1'b1; bus.flush = 1'b1; bus.bubble = 1'b1;
    drive(4'h9, 9'h000, 32'h88, 32'h304, 1'b1);
    step();
    step();
    tests++; if (bus.ex_opcode !== 4'h2 || bus.ex_ctrl !== 9'h1FF || bus.ex_valid !== 1'b1) begin fails++; $display("FAIL hold ctl got %h/%h/%b exp 2/1ff/1", bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
    tests++; if (bus.ex_op_a !== 32'h77 || bus.ex_pc !== 32'h300 || bus.bubble_count !== 16'd3) begin fails++; $display("FAIL hold data/count got %h/%h/%0d exp 77/300/3", bus.ex_op_a, bus.ex_pc, bus.bubble_count); end
    bus.hold = 1'b0;
  endtask

  task automatic test_flush_bubble();
    bus.flush = 1'b1; bus.bubble = 1'b1;
    drive(4'h5, 9'h0AA, 32'h99, 32'h400, 1'b1);
    step();
    tests++; if (bus.ex_opcode !== 4'hE || bus.ex_ctrl !== 9'h0 || bus.ex_valid !== 1'b0) begin fails++; $display("FAIL flush_bubble ctl got %h/%h/%b exp e/0/0", bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
    tests++; if (bus.ex_op_a !== 32'h99 || bus.bubble_count !== 16'd4) begin fails++; $display("FAIL flush_bubble data/count got %h/%0d exp 99/4", bus.ex_op_a, bus.bubble_count); end
    bus.bubble = 1'b0;
    drive(4'h5, 9'h0AA, 32'h1234, 32'h404, 1'b1);
    step();
    tests++; if (bus.ex_opcode !== 4'hE || bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h404) begin fails++; $display("FAIL flush_only got %h/%b/%h exp e/0/404", bus.ex_opcode, bus.ex_valid, bus.ex_pc); end
    tests++; if (bus.bubble_count !== 16'd5) begin fails++; $display("FAIL flush_only count got %0d exp 5", bus.bubble_count); end
    bus.flush = 1'b0;
  endtask

  task automatic test_invalid();
    drive(4'h6, 9'h0F0, 32'h42, 32'h500, 1'b0);
    step();
    tests++; if (bus.ex_opcode !== 4'hE || bus.ex_ctrl !== 9'h0 || bus.ex_valid !== 1'b0) begin fails++; $display("FAIL invalid ctl got %h/%h/%b exp e/0/0", bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
    tests++; if (bus.ex_op_a !== 32'h42 || bus.bubble_count !== 16'd5) begin fails++; $display("FAIL invalid data/count got %h/%0d exp 42/5", bus.ex_op_a, bus.bubble_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3] = '{4'hA, 4'hB, 4'hC};
    logic [8:0]  ctls[3] = '{9'h101, 9'h0C3, 9'h03C};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], ctls[i], 32'h1000 + 32'(i), 32'h600 + 32'(4 * i), 1'b1);
      step();
      tests++; if (bus.ex_opcode !== ops[i] || bus.ex_ctrl !== ctls[i] || bus.ex_valid !== 1'b1 || bus.ex_op_a !== 32'h1000 + 32'(i)) begin fails++; $display("FAIL b2b%0d got %h/%h/%b/%h", i, bus.ex_opcode, bus.ex_ctrl, bus.ex_valid, bus.ex_op_a); end
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(4'h7, 9'h003, 32'h700, 32'h700, 1'b1);
    step();
    bus.hold = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests++; if (bus.ex_opcode !== 4'hE || bus.ex_valid !== 1'b0 || bus.ex_op_a !== 32'h0 || bus.bubble_count !== 16'd0) begin fails++; $display("FAIL reset_in_hold got %h/%b/%h/%0d exp e/0/0/0", bus.ex_opcode, bus.ex_valid, bus.ex_op_a, bus.bubble_count); end
    reset_n = 1'b1;
    step();
    tests++; if (bus.ex_opcode !== 4'hE || bus.ex_op_a !== 32'h0) begin fails++; $display("FAIL post_reset_hold got %h/%h exp e/0", bus.ex_opcode, bus.ex_op_a); end
    bus.hold = 1'b0;
    drive(4'h8, 9'h011, 32'h800, 32'h800, 1'b1);
    step();
    tests++; if (bus.ex_opcode !== 4'h8 || bus.ex_ctrl !== 9'h011 || bus.ex_valid !== 1'b1) begin fails++; $display("FAIL post_reset_load got %h/%h/%b exp 8/011/1", bus.ex_opcode, bus.ex_ctrl, bus.ex_valid); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    sat_bus.id_valid = 1'b1;
    sat_bus.bubble   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      tests++; if (sat_bus.bubble_count !== 4'(exp_cnt)) begin fails++; $display("FAIL saturation%0d got %0d exp %0d", i, sat_bus.bubble_count, exp_cnt); end
    end
    sat_bus.bubble = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    drive(4'h0, 9'h0, 32'h0, 32'h0, 1'b0);
    bus.id_cond = '0; bus.id_rd = '0; bus.id_op_b = '0; bus.id_op_c = '0;
    bus.id_shift_imm = '0; bus.hold = 1'b0; bus.bubble = 1'b0; bus.flush = 1'b0;
    sat_bus.id_opcode = '0; sat_bus.id_ctrl = '0; sat_bus.id_cond = '0; sat_bus.id_rd = '0;
    sat_bus.id_op_a = '0; sat_bus.id_op_b = '0; sat_bus.id_op_c = '0; sat_bus.id_shift_imm = '0;
    sat_bus.id_pc = '0; sat_bus.id_valid = 1'b0; sat_bus.hold = 1'b0;
    sat_bus.bubble = 1'b0; sat_bus.flush = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    test_reset();
    test_normal();
    test_bubble();
    test_hold();
    test_flush_bubble();
    test_invalid();
    test_back_to_back();
    test_reset_mid_hold();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_id_ex_register
`default_nettype wire
